// File: rtl/spi_frame_parser_pkg.sv
// rtl/spi_frame_parser_pkg.sv - error codes, state encodings, CRC-8 constants and SYNC default for spi_frame_parser
package spi_frame_parser_pkg;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_LEN     = 3'd1,
        ERR_CSUM    = 3'd2,
        ERR_OVERRUN = 3'd3,
        ERR_ABORT   = 3'd4
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DELIVER = 3'd4,
        ST_DISCARD = 3'd5
    } state_e;

    localparam logic [7:0] CRC_POLY     = 8'h07;
    localparam logic [7:0] CRC_INIT     = 8'h00;
    localparam logic [3:0] SYNC_DEFAULT = 4'hA;

endpackage

// File: rtl/spi_frame_parser_crc8_byte.sv
// rtl/spi_frame_parser_crc8_byte.sv - combinational byte-wide CRC-8 update, MSB-first, no final XOR
module crc8_byte
    import spi_frame_parser_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/spi_frame_parser.sv
// rtl/spi_frame_parser.sv - SPI word stream to validated payload frames; SPI_FRAME_CRC_EN enables CSUM checking
module spi_frame_parser
    import spi_frame_parser_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter logic [3:0] SYNC    = SYNC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_irq,
    input  logic [7:0] rx_data,
    input  logic       frame_abort,
    output logic [7:0] tx_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [3:0] out_cmd,
    output logic       err_pulse,
    output logic [2:0] err_code
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH     = 1 << IDX_W;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state, state_next;
    logic [3:0] cmd_q;
    logic [7:0] len_q, wr_idx, rd_idx;
    logic [7:0] buf_mem [DEPTH];
    logic [2:0] last_err;
    logic [3:0] frame_cnt;

    logic csum_ok, len_bad, beat, last_beat;
    logic take_flags, take_len, take_pay;
    logic err_set;
    err_e err_val;

    assign len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && out_last;

`ifdef SPI_FRAME_CRC_EN
    logic [7:0] crc_q, crc_seed, crc_next;
    logic       crc_en;

    // A new FLAGS byte restarts the CRC from the init value.
    assign crc_seed = (state == ST_IDLE) ? CRC_INIT : crc_q;
    assign crc_en   = take_flags || take_len || take_pay;
    assign csum_ok  = (rx_data == crc_q);

    crc8_byte u_crc8 (
        .crc_in  (crc_seed),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (crc_en) begin
            crc_q <= crc_next;
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (rx_irq && rx_data[3:0] == SYNC) state_next = ST_LEN;
            ST_LEN:     if (frame_abort) state_next = ST_IDLE;
                        else if (rx_irq) state_next = len_bad ? ST_DISCARD : ST_PAYLOAD;
            ST_PAYLOAD: if (frame_abort) state_next = ST_IDLE;
                        else if (rx_irq && wr_idx == len_q - 8'd1) state_next = ST_CSUM;
            ST_CSUM:    if (frame_abort) state_next = ST_IDLE;
                        else if (rx_irq) state_next = csum_ok ? ST_DELIVER : ST_IDLE;
            ST_DELIVER: if (last_beat) state_next = ST_IDLE;
            ST_DISCARD: if (frame_abort) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid  = (state == ST_DELIVER);
        out_last   = out_valid && (rd_idx == len_q - 8'd1);
        out_data   = out_valid ? buf_mem[rd_idx[IDX_W-1:0]] : 8'h00;
        take_flags = (state == ST_IDLE) && rx_irq && (rx_data[3:0] == SYNC);
        take_len   = (state == ST_LEN) && rx_irq && !frame_abort && !len_bad;
        take_pay   = (state == ST_PAYLOAD) && rx_irq && !frame_abort;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        if ((state == ST_LEN || state == ST_PAYLOAD || state == ST_CSUM) && frame_abort) begin
            err_set = 1'b1;
            err_val = ERR_ABORT;
        end else if (state == ST_LEN && rx_irq && len_bad) begin
            err_set = 1'b1;
            err_val = ERR_LEN;
        end else if (state == ST_CSUM && rx_irq && !csum_ok) begin
            err_set = 1'b1;
            err_val = ERR_CSUM;
        end else if (state == ST_DELIVER && rx_irq) begin
            err_set = 1'b1;
            err_val = ERR_OVERRUN;
        end
    end

    always_ff @(posedge clk) begin
        if (take_pay) begin
            buf_mem[wr_idx[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= 4'd0;
            len_q     <= 8'd0;
            wr_idx    <= 8'd0;
            rd_idx    <= 8'd0;
            frame_cnt <= 4'd0;
            last_err  <= ERR_NONE;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
            tx_data   <= 8'h00;
        end else begin
            err_pulse <= err_set;
            if (take_flags) cmd_q <= rx_data[7:4];
            if (take_len) begin
                len_q  <= rx_data;
                wr_idx <= 8'd0;
            end
            if (take_pay) wr_idx <= wr_idx + 8'd1;
            if (state == ST_CSUM) rd_idx <= 8'd0;
            if (beat) rd_idx <= rd_idx + 8'd1;
            if (last_beat) begin
                frame_cnt <= frame_cnt + 4'd1;
                last_err  <= ERR_NONE;
            end
            // A newer error outranks the clear from a completed delivery.
            if (err_set) begin
                err_code <= err_val;
                last_err <= err_val;
            end
            tx_data <= {state != ST_IDLE, last_err, frame_cnt};
        end
    end

    assign out_cmd = cmd_q;

endmodule

// File: tb/tb_spi_frame_parser.sv
// tb/tb_spi_frame_parser.sv - directed self-checking bench for spi_frame_parser
module tb_spi_frame_parser;

    logic       clk = 1'b0;
    logic       rst, rx_irq, frame_abort, out_ready;
    logic [7:0] rx_data, tx_data, out_data;
    logic       out_valid, out_last, err_pulse;
    logic [3:0] out_cmd;
    logic [2:0] err_code;

    always #5 clk = ~clk;

    spi_frame_parser dut (
        .clk(clk), .rst(rst), .rx_irq(rx_irq), .rx_data(rx_data),
        .frame_abort(frame_abort), .tx_data(tx_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_cmd(out_cmd), .err_pulse(err_pulse), .err_code(err_code)
    );

    int checks = 0;
    int passes = 0;
    int err_seen = 0;
    logic [2:0] err_last_code = 3'd0;
    logic [3:0] exp_cnt = 4'd0;
    logic [2:0] exp_le = 3'd0;
    logic [7:0] beat_data[$];
    logic       beat_last[$];
    logic [3:0] beat_cmd[$];
    int  stab_err;
    bit  timed_out;

    always @(negedge clk) begin
        if (err_pulse === 1'b1) begin
            err_seen++;
            err_last_code = err_code;
        end
    end

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_irq  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_irq  = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        frame_abort = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready low two cycles, high two cycles
    task automatic collect(input int mode, input int inject_at);
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        bit         done = 1'b0;
        beat_data.delete();
        beat_last.delete();
        beat_cmd.delete();
        stab_err  = 0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
            out_ready = (mode == 0) ? 1'b1 : (((cyc / 2) % 2) == 1);
            rx_irq    = (cyc == inject_at);
            rx_data   = 8'h77;
            if (out_valid === 1'b1 && out_ready) begin
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
                beat_cmd.push_back(out_cmd);
                if (out_last === 1'b1) begin
                    done = 1'b1;
                    timed_out = 1'b0;
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
        end
        rx_irq    = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic send_good();
        send_byte(8'h1A);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h9C);
        collect(0, -1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
        checks++; if (out_last !== 1'b0 || out_data !== 8'h00 || out_cmd !== 4'h0)
            $display("FAIL reset_out_bus got last=%b data=%h cmd=%h exp 0/00/0", out_last, out_data, out_cmd); else passes++;
        checks++; if (err_pulse !== 1'b0 || err_code !== 3'd0)
            $display("FAIL reset_err got pulse=%b code=%0d exp 0/0", err_pulse, err_code); else passes++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx got %h exp 00", tx_data); else passes++;
    endtask

    task automatic test_good_frame();
        int e0 = err_seen;
        send_byte(8'h1A);
        checks++; if (tx_data !== 8'h00) $display("FAIL good_tx_first got %h exp 00", tx_data); else passes++;
        send_byte(8'h01);
        checks++; if (tx_data !== 8'h80) $display("FAIL good_tx_busy got %h exp 80", tx_data); else passes++;
        send_byte(8'h55);
        send_byte(8'h9C);
        checks++; if (out_valid !== 1'b1) $display("FAIL good_valid_latency got %b exp 1", out_valid); else passes++;
        collect(0, -1);
        exp_cnt++;
        checks++; if (timed_out || beat_data.size() != 1) $display("FAIL good_beats got %0d exp 1", beat_data.size());
        else begin
            passes++;
            checks++; if (beat_data[0] !== 8'h55 || beat_last[0] !== 1'b1 || beat_cmd[0] !== 4'h1)
                $display("FAIL good_beat got data=%h last=%b cmd=%h exp 55/1/1", beat_data[0], beat_last[0], beat_cmd[0]);
            else passes++;
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL good_valid_drop got %b exp 0", out_valid); else passes++;
        idle(2);
        checks++; if (err_seen != e0) $display("FAIL good_no_err got %0d errors exp 0", err_seen - e0); else passes++;
        checks++; if (tx_data !== 8'h01) $display("FAIL good_tx_after got %h exp 01", tx_data); else passes++;
    endtask

    task automatic test_bad_crc();
        send_byte(8'h1A);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h9D);
`ifdef SPI_FRAME_CRC_EN
        checks++; if (err_pulse !== 1'b1 || err_code !== 3'd2)
            $display("FAIL crc_err got pulse=%b code=%0d exp 1/2", err_pulse, err_code); else passes++;
        exp_le = 3'd2;
        idle(3);
        checks++; if (out_valid !== 1'b0) $display("FAIL crc_no_valid got %b exp 0", out_valid); else passes++;
`else
        checks++; if (err_pulse !== 1'b0) $display("FAIL crc_ignored_err got %b exp 0", err_pulse); else passes++;
        collect(0, -1);
        exp_cnt++;
        checks++; if (timed_out || beat_data.size() != 1 || beat_data[0] !== 8'h55)
            $display("FAIL crc_ignored_deliver got %0d beats exp 1 of 55", beat_data.size()); else passes++;
        idle(2);
`endif
        checks++; if (tx_data !== {1'b0, exp_le, exp_cnt})
            $display("FAIL crc_tx got %h exp %h", tx_data, {1'b0, exp_le, exp_cnt}); else passes++;
    endtask

    task automatic test_len_error();
        int e0;
        send_byte(8'h1A);
        send_byte(8'h00);
        checks++; if (err_pulse !== 1'b1 || err_code !== 3'd1)
            $display("FAIL len_err got pulse=%b code=%0d exp 1/1", err_pulse, err_code); else passes++;
        exp_le = 3'd1;
        e0 = err_seen + 1;
        send_byte(8'h33);
        send_byte(8'h44);
        idle(2);
        checks++; if (tx_data !== {1'b1, exp_le, exp_cnt})
            $display("FAIL len_discard_busy got %h exp %h", tx_data, {1'b1, exp_le, exp_cnt}); else passes++;
        pulse_abort();
        idle(2);
        checks++; if (err_seen != e0) $display("FAIL len_quiet_discard got %0d errors exp %0d", err_seen, e0); else passes++;
        checks++; if (tx_data !== {1'b0, exp_le, exp_cnt})
            $display("FAIL len_back_idle got %h exp %h", tx_data, {1'b0, exp_le, exp_cnt}); else passes++;
        send_good();
        exp_cnt++;
        exp_le = 3'd0;
        checks++; if (timed_out || beat_data.size() != 1 || beat_data[0] !== 8'h55)
            $display("FAIL len_next_good got %0d beats exp 1 of 55", beat_data.size()); else passes++;
        idle(2);
        checks++; if (tx_data !== {1'b0, exp_le, exp_cnt})
            $display("FAIL len_tx_clear got %h exp %h", tx_data, {1'b0, exp_le, exp_cnt}); else passes++;
    endtask

    task automatic test_backpressure_overrun();
        logic [7:0] c;
        logic [7:0] exp_d [4];
        int e0 = err_seen;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        c = crc_step(8'h00, 8'h2A);
        c = crc_step(c, 8'h04);
        for (int i = 0; i < 4; i++) c = crc_step(c, exp_d[i]);
        send_byte(8'h2A);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) send_byte(exp_d[i]);
        send_byte(c);
        collect(1, 1);
        exp_cnt++;
        checks++; if (timed_out || beat_data.size() != 4) $display("FAIL bp_beats got %0d exp 4", beat_data.size());
        else begin
            passes++;
            for (int i = 0; i < 4; i++) begin
                checks++; if (beat_data[i] !== exp_d[i] || beat_last[i] !== (i == 3) || beat_cmd[i] !== 4'h2)
                    $display("FAIL bp_beat%0d got data=%h last=%b cmd=%h exp %h/%b/2",
                             i, beat_data[i], beat_last[i], beat_cmd[i], exp_d[i], (i == 3));
                else passes++;
            end
        end
        checks++; if (stab_err != 0) $display("FAIL bp_stable got %0d changes exp 0", stab_err); else passes++;
        idle(2);
        checks++; if (err_seen != e0 + 1 || err_last_code !== 3'd3)
            $display("FAIL bp_overrun got %0d errors code %0d exp 1 code 3", err_seen - e0, err_last_code); else passes++;
        checks++; if (tx_data !== {1'b0, 3'd0, exp_cnt})
            $display("FAIL bp_tx got %h exp %h", tx_data, {1'b0, 3'd0, exp_cnt}); else passes++;
    endtask

    task automatic test_abort();
        int e0;
        send_byte(8'h3A);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_abort();
        checks++; if (err_pulse !== 1'b1 || err_code !== 3'd4)
            $display("FAIL abort_err got pulse=%b code=%0d exp 1/4", err_pulse, err_code); else passes++;
        exp_le = 3'd4;
        idle(2);
        e0 = err_seen;
        send_byte(8'h12);
        idle(3);
        checks++; if (err_seen != e0 || out_valid !== 1'b0)
            $display("FAIL abort_resync got %0d errors valid=%b exp 0/0", err_seen - e0, out_valid); else passes++;
        checks++; if (tx_data !== {1'b0, exp_le, exp_cnt})
            $display("FAIL abort_tx got %h exp %h", tx_data, {1'b0, exp_le, exp_cnt}); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int e0 = err_seen;
        send_byte(8'h5A);
        send_byte(8'h02);
        send_byte(8'hAA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 4'd0;
        exp_le  = 3'd0;
        checks++; if (tx_data !== 8'h00 || err_code !== 3'd0 || out_cmd !== 4'h0 || out_valid !== 1'b0)
            $display("FAIL rst_mid got tx=%h code=%0d cmd=%h valid=%b exp 00/0/0/0", tx_data, err_code, out_cmd, out_valid);
        else passes++;
        send_good();
        exp_cnt++;
        idle(2);
        checks++; if (timed_out || beat_data.size() != 1 || beat_data[0] !== 8'h55 || beat_cmd[0] !== 4'h1)
            $display("FAIL rst_next_good got %0d beats exp 1 of 55", beat_data.size()); else passes++;
        checks++; if (err_seen != e0) $display("FAIL rst_no_err got %0d errors exp 0", err_seen - e0); else passes++;
        checks++; if (tx_data !== {1'b0, exp_le, exp_cnt})
            $display("FAIL rst_tx got %h exp %h", tx_data, {1'b0, exp_le, exp_cnt}); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        rx_irq = 1'b0;
        rx_data = 8'h00;
        frame_abort = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_len_error();
        test_backpressure_overrun();
        test_abort();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
